// File: rtl/vec_acc_25p.sv
// vec_acc_25p
//   Sequential reduction of a packed N-lane Q8.8 product bus plus a bias term
//   into one saturated Q8.8 scalar. One lane is added per cycle through a single
//   adder, in ascending lane order.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous, active-low reset
//   in_valid   in_vec / in_bias are valid
//   in_ready   block can accept a vector (registered, high only in IDLE)
//   in_vec     packed lanes, lane k at [k*W +: W], lane 0 in the LSBs
//   in_bias    Q8.8 bias, added once per vector
//   out_valid  out_data holds a result
//   out_ready  downstream accepts out_data
//   out_data   saturated Q8.8 sum
//   busy       high while in ACC or OUT
//
// state | meaning
// IDLE  | waiting for an input handshake, in_ready=1
// ACC   | adding lane[idx] to the accumulator, one lane per cycle
// OUT   | result held on out_data until the output handshake
module vec_acc_25p #(
   parameter int N = 25,
   parameter int W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N*W-1:0]   in_vec,
   input  logic [W-1:0]     in_bias,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_data,
   output logic             busy
);

   // Headroom for N lanes plus the bias at full negative/positive scale.
   localparam int ACC_W = W + 6;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};
   localparam logic [W-1:0] SAT_POS = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] SAT_NEG = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t                   state;
   logic [N*W-1:0]           vec_q;
   logic signed [ACC_W-1:0]  acc;
   logic [IDX_W-1:0]         idx;

   logic [W-1:0]             lane;
   logic signed [ACC_W-1:0]  sum;
   logic [W-1:0]             sat;

   always_comb begin
      lane = vec_q[idx*W +: W];
      sum  = acc + {{(ACC_W-W){lane[W-1]}}, lane};
      if (sum > MAX_V)
         sat = SAT_POS;
      else if (sum < MIN_V)
         sat = SAT_NEG;
      else
         sat = sum[W-1:0];
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         vec_q     <= '0;
         acc       <= '0;
         idx       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  vec_q    <= in_vec;
                  acc      <= {{(ACC_W-W){in_bias[W-1]}}, in_bias};
                  idx      <= '0;
                  in_ready <= 1'b0;
                  state    <= ACC;
               end
            end
            ACC: begin
               acc <= sum;
               if (idx == IDX_W'(N-1)) begin
                  out_data  <= sat;
                  out_valid <= 1'b1;
                  state     <= OUT;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vec_acc_25p.sv
// tb_vec_acc_25p
//   Directed bench for vec_acc_25p. The stimulus process pushes the expected
//   Q8.8 result of each vector into a queue; a separate monitor pops and
//   compares on every output handshake.
module tb_vec_acc_25p;

   localparam int N = 25;
   localparam int W = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [N*W-1:0]   in_vec;
   logic [W-1:0]     in_bias;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     out_data;
   logic             busy;

   int errors = 0;
   int checks = 0;
   logic [W-1:0] exp_q[$];

   vec_acc_25p #(.N(N), .W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_vec    (in_vec),
      .in_bias   (in_bias),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Inputs change at negedge; sampling 1 ns later sees exactly what the next
   // posedge will see, so this predicts each output handshake.
   always begin
      @(negedge clk);
      #1;
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %h expected none", out_data);
         end else begin
            check("out_data", {16'h0, out_data}, {16'h0, exp_q.pop_front()});
         end
      end
   end

   function automatic logic [N*W-1:0] fill_all(input logic [W-1:0] v);
      logic [N*W-1:0] r;
      for (int k = 0; k < N; k++) r[k*W +: W] = v;
      return r;
   endfunction

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input logic [N*W-1:0] v, input logic [W-1:0] b,
                       input logic [W-1:0] e, input bit push);
      int t = 0;
      while (in_ready !== 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("send_ready", {31'h0, in_ready}, 32'h1);
      in_vec   = v;
      in_bias  = b;
      in_valid = 1'b1;
      if (push) exp_q.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Counts posedges after the accepting edge until out_valid is seen.
   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 100) begin
         @(posedge clk);
         cyc++;
         #1;
      end
      @(negedge clk);
   endtask

   task automatic drain(input string name);
      int t = 0;
      while (exp_q.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      check({name, "_drained"}, exp_q.size(), 32'h0);
   endtask

   initial begin
      logic [N*W-1:0] v;
      int cyc;
      int seen;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_vec    = '0;
      in_bias   = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("rst_in_ready", {31'h0, in_ready}, 32'h1);
         check("rst_out_valid", {31'h0, out_valid}, 32'h0);
         check("rst_out_data", {16'h0, out_data}, 32'h0);
         check("rst_busy", {31'h0, busy}, 32'h0);
      end

      // Unit sum: 25 * 1.0 + 0.5 = 25.5, plus latency of N edges.
      out_ready = 1'b1;
      send(fill_all(16'h0100), 16'h0080, 16'h1980, 1'b1);
      check("busy_in_acc", {31'h0, busy}, 32'h1);
      check("in_ready_in_acc", {31'h0, in_ready}, 32'h0);
      wait_valid(cyc);
      check("latency", cyc, 32'd25);
      drain("unit");

      // Saturation both ways.
      send(fill_all(16'hC230), 16'h0000, 16'h8000, 1'b1);
      drain("neg_sat");
      send(fill_all(16'h7FFF), 16'h7FFF, 16'h7FFF, 1'b1);
      drain("pos_sat");

      // Lane order / sign, then swapped lanes give the same sum.
      v = '0;
      v[0 +: W]      = 16'h0200;
      v[24*W +: W]   = 16'hFF00;
      send(v, 16'hFF80, 16'h0080, 1'b1);
      drain("lane_order");
      v = '0;
      v[0 +: W]      = 16'hFF00;
      v[24*W +: W]   = 16'h0200;
      send(v, 16'hFF80, 16'h0080, 1'b1);
      drain("lane_swap");

      // Distinct per-lane values 0x10*k: sum 16*300 = 0x12C0.
      for (int k = 0; k < N; k++) v[k*W +: W] = 16'(k * 16);
      send(v, 16'h0000, 16'h12C0, 1'b1);
      drain("ramp");

      // Stall with ignored input: 25 * 0x0001 + 0x0010 = 0x0029.
      out_ready = 1'b0;
      send(fill_all(16'h0001), 16'h0010, 16'h0029, 1'b1);
      wait_valid(cyc);
      check("stall_valid_seen", {31'h0, out_valid}, 32'h1);
      in_vec   = fill_all(16'h0300);
      in_bias  = 16'h0100;
      in_valid = 1'b1;
      repeat (10) begin
         @(negedge clk);
         check("stall_data", {16'h0, out_data}, 32'h0029);
         check("stall_in_ready", {31'h0, in_ready}, 32'h0);
         check("stall_valid", {31'h0, out_valid}, 32'h1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("release_valid", {31'h0, out_valid}, 32'h0);
      check("release_in_ready", {31'h0, in_ready}, 32'h1);
      check("release_busy", {31'h0, busy}, 32'h0);
      seen = 0;
      repeat (30) begin
         @(negedge clk);
         if (out_valid === 1'b1) seen++;
      end
      check("ignored_not_taken", seen, 32'h0);
      drain("stall");

      // Reset at lane index 12: no output, then a clean vector.
      send(fill_all(16'h0100), 16'h0000, 16'h0000, 1'b0);
      repeat (12) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check("midrst_in_ready", {31'h0, in_ready}, 32'h1);
      check("midrst_busy", {31'h0, busy}, 32'h0);
      check("midrst_out_data", {16'h0, out_data}, 32'h0);
      seen = 0;
      repeat (30) begin
         @(negedge clk);
         if (out_valid === 1'b1) seen++;
      end
      check("midrst_no_valid", seen, 32'h0);
      send(fill_all(16'h0100), 16'h0000, 16'h1900, 1'b1);
      drain("after_rst");

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
